// File: rtl/kaliski_pkg.sv
// Shared FSM state type and sizing helpers for the Kaliski phase-I engine.
package kaliski_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOP,
    CORR,
    NEG,
    DONE
  } state_e;

  localparam int unsigned N_DEF  = 256;
  localparam int unsigned GS_DEF = 4;

  // Width of the iteration counter: k can reach 2N.
  function automatic int unsigned kw_f(input int unsigned n);
    return $clog2(2 * n + 1);
  endfunction

  // N+1 bits rounded up to a whole number of adder groups.
  function automatic int unsigned add_w_f(input int unsigned n, input int unsigned gs);
    return gs * ((n + gs) / gs);
  endfunction

endpackage

// File: rtl/kaliski_adder.sv
// Group-prefix adder: ripple inside GS-bit groups, log-depth prefix across
// group generate/propagate pairs. W must be a multiple of GS.
module kaliski_adder #(
  parameter int unsigned W  = 12,
  parameter int unsigned GS = 4
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_c,
  output logic         cout_c
);

  localparam int unsigned NG = W / GS;
  localparam int unsigned LV = $clog2(NG);

  function automatic logic [W:0] pfx_add(input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input logic         cin);
    logic [W-1:0]  g;
    logic [W-1:0]  p;
    logic [W-1:0]  s;
    logic [NG-1:0] gg;
    logic [NG-1:0] gp;
    logic          c;
    g = a & b;
    p = a ^ b;
    for (int unsigned i = 0; i < NG; i++) begin
      gg[i] = 1'b0;
      gp[i] = 1'b1;
      for (int unsigned j = 0; j < GS; j++) begin
        gg[i] = g[i*GS+j] | (p[i*GS+j] & gg[i]);
        gp[i] = gp[i] & p[i*GS+j];
      end
    end
    // Fold carry-in into group 0 so every prefix term is a true carry-out.
    gg[0] = gg[0] | (gp[0] & cin);
    for (int unsigned l = 0; l < LV; l++) begin
      for (int unsigned i = 0; i < NG; i++) begin
        if (((i >> l) & 1) != 0) begin
          gg[i] = gg[i] | (gp[i] & gg[((i >> l) << l) - 1]);
          gp[i] = gp[i] & gp[((i >> l) << l) - 1];
        end
      end
    end
    c = cin;
    s = '0;
    for (int unsigned i = 0; i < NG; i++) begin
      for (int unsigned j = 0; j < GS; j++) begin
        s[i*GS+j] = p[i*GS+j] ^ c;
        c         = g[i*GS+j] | (p[i*GS+j] & c);
      end
      c = gg[i];
    end
    return {c, s};
  endfunction

  assign {cout_c, sum_c} = pfx_add(a_i, b_i, cin_i);

endmodule

// File: rtl/kaliski_sub.sv
// Subtract/compare wrapper: diff = a - b, ge = (a >= b) from the adder carry.
module kaliski_sub #(
  parameter int unsigned W  = 12,
  parameter int unsigned GS = 4
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] diff_c,
  output logic         ge_c
);

  logic [W-1:0] b_inv;

  assign b_inv = ~b_i;

  kaliski_adder #(
    .W (W),
    .GS(GS)
  ) u_add (
    .a_i   (a_i),
    .b_i   (b_inv),
    .cin_i (1'b1),
    .sum_c (diff_c),
    .cout_c(ge_c)
  );

endmodule

// File: rtl/kaliski_phase1.sv
// Kaliski phase-I almost-inverse engine: R = a^-1 * 2^k mod p, one iteration per clock.
// Optional gcd/zero error flag enabled by defining KALISKI_GCD_CHECK_EN.
module kaliski_phase1
  import kaliski_pkg::*;
#(
  parameter int unsigned N  = N_DEF,
  parameter int unsigned GS = GS_DEF,
  parameter int unsigned KW = kw_f(N)
) (
  input  logic          clk,
  input  logic          rst_ni,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  a_i,
  input  logic [N-1:0]  p_i,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  r_o,
  output logic [KW-1:0] k_o,
  output logic          err_o
);

  localparam int unsigned ADD_W = add_w_f(N, GS);
  localparam int unsigned RW    = N + 1;

  state_e        state_q, state_d;
  logic [RW-1:0] u_q, u_d, v_q, v_d, r_q, r_d, s_q, s_d;
  logic [N-1:0]  p_q, p_d;
  logic [KW-1:0] k_q, k_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic [N-1:0]  r_o_q, r_o_d;
  logic [KW-1:0] k_o_q, k_o_d;
`ifdef KALISKI_GCD_CHECK_EN
  logic          err_q, err_d;
`endif

  logic [ADD_W-1:0] x_a, x_b, x_diff;
  logic [ADD_W-1:0] y_a, y_b, y_diff;
  logic [ADD_W-1:0] z_a, z_b, z_sum;
  logic             x_ge, y_ge, z_co;
  logic             u_gt_v;
  logic             unused_adder;

  // X and Y are shared between the loop compare and the CORR/NEG steps.
  always_comb begin
    x_a = ADD_W'(u_q);
    x_b = ADD_W'(v_q);
    y_a = ADD_W'(v_q);
    y_b = ADD_W'(u_q);
    if (state_q == CORR) begin
      x_a = ADD_W'(r_q);
      x_b = ADD_W'(p_q);
    end
    if (state_q == NEG) begin
      y_a = ADD_W'(p_q);
      y_b = ADD_W'(r_q);
    end
  end

  assign z_a = ADD_W'(r_q);
  assign z_b = ADD_W'(s_q);

  kaliski_sub #(
    .W (ADD_W),
    .GS(GS)
  ) u_sub_x (
    .a_i   (x_a),
    .b_i   (x_b),
    .diff_c(x_diff),
    .ge_c  (x_ge)
  );

  kaliski_sub #(
    .W (ADD_W),
    .GS(GS)
  ) u_sub_y (
    .a_i   (y_a),
    .b_i   (y_b),
    .diff_c(y_diff),
    .ge_c  (y_ge)
  );

  kaliski_adder #(
    .W (ADD_W),
    .GS(GS)
  ) u_add_z (
    .a_i   (z_a),
    .b_i   (z_b),
    .cin_i (1'b0),
    .sum_c (z_sum),
    .cout_c(z_co)
  );

  assign u_gt_v       = x_ge && (u_q != v_q);
  // Operands never exceed N+1 bits, so the padding bits and carries are don't-care.
  assign unused_adder = ^{x_diff, y_diff, z_sum, z_co, y_ge};

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      u_q         <= '0;
      v_q         <= '0;
      r_q         <= '0;
      s_q         <= '0;
      p_q         <= '0;
      k_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      r_o_q       <= '0;
      k_o_q       <= '0;
`ifdef KALISKI_GCD_CHECK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      u_q         <= u_d;
      v_q         <= v_d;
      r_q         <= r_d;
      s_q         <= s_d;
      p_q         <= p_d;
      k_q         <= k_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      r_o_q       <= r_o_d;
      k_o_q       <= k_o_d;
`ifdef KALISKI_GCD_CHECK_EN
      err_q       <= err_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    u_d         = u_q;
    v_d         = v_q;
    r_d         = r_q;
    s_d         = s_q;
    p_d         = p_q;
    k_d         = k_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    r_o_d       = r_o_q;
    k_o_d       = k_o_q;
`ifdef KALISKI_GCD_CHECK_EN
    err_d       = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          u_d        = RW'(p_i);
          v_d        = RW'(a_i);
          r_d        = '0;
          s_d        = RW'(1);
          k_d        = '0;
          p_d        = p_i;
          in_ready_d = 1'b0;
          state_d    = LOOP;
        end
      end
      LOOP: begin
        // The k bound only bites on illegal operands and guarantees termination.
        if (v_q == '0 || k_q == KW'(2 * N)) begin
          state_d = CORR;
`ifdef KALISKI_GCD_CHECK_EN
          err_d   = (u_q != RW'(1));
`endif
        end else begin
          k_d = k_q + KW'(1);
          if (!u_q[0]) begin
            u_d = u_q >> 1;
            s_d = s_q << 1;
          end else if (!v_q[0]) begin
            v_d = v_q >> 1;
            r_d = r_q << 1;
          end else if (u_gt_v) begin
            u_d = {1'b0, x_diff[RW-1:1]};
            r_d = z_sum[RW-1:0];
            s_d = s_q << 1;
          end else begin
            v_d = {1'b0, y_diff[RW-1:1]};
            s_d = z_sum[RW-1:0];
            r_d = r_q << 1;
          end
        end
      end
      CORR: begin
        if (x_ge) begin
          r_d = x_diff[RW-1:0];
        end
        state_d = NEG;
      end
      NEG: begin
        r_o_d       = (r_q == '0) ? '0 : y_diff[N-1:0];
        k_o_d       = k_q;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign r_o       = r_o_q;
  assign k_o       = k_o_q;
`ifdef KALISKI_GCD_CHECK_EN
  assign err_o     = err_q;
`else
  assign err_o     = 1'b0;
`endif

endmodule

// File: tb/tb_kaliski_phase1.sv
// Self-checking bench for kaliski_phase1 at N=8 against an integer Kaliski model.
module tb_kaliski_phase1;

  localparam int unsigned N      = 8;
  localparam int unsigned GS     = 4;
  localparam int unsigned KW     = $clog2(2 * N + 1);
  localparam int unsigned BUDGET = 2 * N + 12;

  logic          clk;
  logic          rst_ni;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  a_i;
  logic [N-1:0]  p_i;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  r_o;
  logic [KW-1:0] k_o;
  logic          err_o;

  int unsigned errors = 0;
  int unsigned checks = 0;

  kaliski_phase1 #(
    .N (N),
    .GS(GS),
    .KW(KW)
  ) dut (
    .clk      (clk),
    .rst_ni   (rst_ni),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_i      (a_i),
    .p_i      (p_i),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .r_o      (r_o),
    .k_o      (k_o),
    .err_o    (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Kaliski phase I on plain integers, followed by the final p - r step.
  function automatic void model(input int unsigned p, input int unsigned a,
                                output int unsigned r_exp, output int unsigned k_exp,
                                output bit coprime);
    int unsigned u = p;
    int unsigned v = a;
    int unsigned r = 0;
    int unsigned s = 1;
    int unsigned k = 0;
    while (v != 0) begin
      if (u % 2 == 0) begin
        u = u / 2; s = s * 2;
      end else if (v % 2 == 0) begin
        v = v / 2; r = r * 2;
      end else if (u > v) begin
        u = (u - v) / 2; r = r + s; s = s * 2;
      end else begin
        v = (v - u) / 2; s = s + r; r = r * 2;
      end
      k++;
    end
    if (r >= p) r = r - p;
    r_exp   = (r == 0) ? 0 : p - r;
    k_exp   = k;
    coprime = (u == 1);
  endfunction

  function automatic int unsigned err_of(input bit coprime);
`ifdef KALISKI_GCD_CHECK_EN
    return coprime ? 0 : 1;
`else
    return 0;
`endif
  endfunction

  function automatic int unsigned pow2mod(input int unsigned k, input int unsigned p);
    int unsigned x = 1 % p;
    for (int unsigned i = 0; i < k; i++) x = (x * 2) % p;
    return x;
  endfunction

  // One full handshake: offer operands, wait for result, hold, then accept it.
  task automatic xact(input int unsigned p, input int unsigned a, input int unsigned hold,
                      input string tag, input int unsigned r_exp, input int unsigned k_exp,
                      input int unsigned err_exp, input bit coprime);
    int unsigned n;
    int unsigned lat;
    p_i       = N'(p);
    a_i       = N'(a);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < BUDGET) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < BUDGET) begin
      @(posedge clk); #1; lat++;
    end
    chk({tag, ".lat"}, lat, k_exp + 4);
    chk({tag, ".r"}, 32'(r_o), r_exp);
    chk({tag, ".k"}, 32'(k_o), k_exp);
    chk({tag, ".err"}, 32'(err_o), err_exp);
    chk({tag, ".in_ready"}, 32'(in_ready), 0);
    if (coprime && a != 0)
      chk({tag, ".mod"}, (32'(r_o) * a) % p, pow2mod(32'(k_o), p));
    for (int unsigned i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, ".hold_v"}, 32'(out_valid), 1);
      chk({tag, ".hold_r"}, 32'(r_o), r_exp);
      chk({tag, ".hold_k"}, 32'(k_o), k_exp);
      chk({tag, ".hold_rdy"}, 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, ".drop_v"}, 32'(out_valid), 0);
    chk({tag, ".idle_rdy"}, 32'(in_ready), 1);
  endtask

  initial begin
    int unsigned rx, kx, p, a;
    bit          cp;
    int unsigned bp[4] = '{13, 7, 11, 251};
    int unsigned ba[4] = '{5, 1, 2, 100};
    int unsigned qr[$];
    int unsigned qk[$];
    int unsigned nsent, ndone;
    bit          acc, prev_ov;

    rst_ni = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a_i = '0; p_i = '0;
    #12;
    chk("rst.in_ready", 32'(in_ready), 1);
    chk("rst.out_valid", 32'(out_valid), 0);
    chk("rst.r", 32'(r_o), 0);
    chk("rst.k", 32'(k_o), 0);
    chk("rst.err", 32'(err_o), 0);
    @(posedge clk); #1; rst_ni = 1'b1;
    @(posedge clk); #1;

    xact(13, 5, 0, "p13a5", 5, 6, 0, 1'b1);
    xact(7, 1, 5, "p7a1", 1, 3, 0, 1'b1);
    xact(13, 0, 0, "a0", 0, 0, err_of(1'b0), 1'b0);
    xact(9, 3, 1, "p9a3", 7, 2, err_of(1'b0), 1'b0);

    // Reset in the middle of LOOP discards the operation.
    p_i = 8'd13; a_i = 8'd5; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_ni = 1'b0;
    #1;
    chk("midrst.in_ready", 32'(in_ready), 1);
    chk("midrst.out_valid", 32'(out_valid), 0);
    chk("midrst.r", 32'(r_o), 0);
    chk("midrst.k", 32'(k_o), 0);
    chk("midrst.err", 32'(err_o), 0);
    @(posedge clk); #1; rst_ni = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("midrst.no_output", 32'(out_valid), 0);
    model(11, 2, rx, kx, cp);
    xact(11, 2, 0, "p11a2", rx, kx, err_of(cp), cp);

    // Back-to-back: in_valid and out_ready held high throughout.
    nsent = 0; ndone = 0; prev_ov = 1'b0;
    p_i = N'(bp[0]); a_i = N'(ba[0]); in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 400 && ndone < 4; c++) begin
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) begin
        model(bp[nsent], ba[nsent], rx, kx, cp);
        qr.push_back(rx);
        qk.push_back(kx);
        nsent++;
        if (nsent < 4) begin
          p_i = N'(bp[nsent]); a_i = N'(ba[nsent]);
        end else begin
          in_valid = 1'b0;
        end
      end
      if (prev_ov) begin
        chk("b2b.drop_v", 32'(out_valid), 0);
        chk("b2b.rdy_after", 32'(in_ready), 1);
      end
      if (out_valid) begin
        chk("b2b.pending", 32'(qr.size()), 32'(nsent - ndone));
        if (qr.size() > 0) begin
          chk("b2b.r", 32'(r_o), qr.pop_front());
          chk("b2b.k", 32'(k_o), qk.pop_front());
        end
        ndone++;
      end
      prev_ov = out_valid;
    end
    chk("b2b.sent", nsent, 4);
    chk("b2b.done", ndone, 4);
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;

    // Random odd moduli with 0 < a < p, every tenth case a = p-1.
    for (int i = 0; i < 300; i++) begin
      p = 2 * $urandom_range(1, 127) + 1;
      a = (i % 10 == 0) ? p - 1 : $urandom_range(1, p - 1);
      model(p, a, rx, kx, cp);
      xact(p, a, $urandom_range(0, 2), "rand", rx, kx, err_of(cp), cp);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
